// File: rtl/nn_img_loader.sv
// Packs a stream of DATA_WIDTH pixels into 6-lane words and writes them to an image buffer.
// Define NN_IMG_LOADER_PAD_EN to zero-pad and write a partial word that ends on i_last; otherwise it is dropped.
module nn_img_loader #(
  parameter int DATA_WIDTH       = 8,
  parameter int ADDR_WIDTH       = 10,
  parameter int TOTAL_DATA_WIDTH = DATA_WIDTH*6
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic [ADDR_WIDTH-1:0]       i_base_addr,
  input  logic [ADDR_WIDTH:0]         i_num_words,
  input  logic                        i_valid,
  input  logic [DATA_WIDTH-1:0]       i_data,
  input  logic                        i_last,
  output logic                        o_ready,
  output logic                        o_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_wr_addr0,
  output logic [TOTAL_DATA_WIDTH-1:0] o_wr_data0,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [ADDR_WIDTH:0]         o_words_written
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  localparam logic [2:0]          LAST_LANE = 3'd5;
  localparam logic [2:0]          LANE_ONE  = 3'd1;
  localparam logic [ADDR_WIDTH:0] WORD_ONE  = 1;

  state_t                      state;
  logic [ADDR_WIDTH-1:0]       base_q;
  logic [ADDR_WIDTH:0]         target_q;
  logic [2:0]                  lane_cnt;
  logic [ADDR_WIDTH:0]         word_cnt;
  logic [TOTAL_DATA_WIDTH-1:0] word_buf;
  logic [TOTAL_DATA_WIDTH-1:0] assembled;
  logic [ADDR_WIDTH:0]         words_next;
  logic [ADDR_WIDTH-1:0]       wr_addr_next;
  logic                        accept;

  // Lanes above the current one are always zero in word_buf, which gives zero padding for free.
  always_comb begin
    assembled = word_buf;
    assembled[int'(lane_cnt)*DATA_WIDTH +: DATA_WIDTH] = i_data;
  end

  assign accept          = i_valid && o_ready;
  assign words_next      = word_cnt + WORD_ONE;
  assign wr_addr_next    = base_q + word_cnt[ADDR_WIDTH-1:0];
  assign o_words_written = word_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      base_q     <= '0;
      target_q   <= '0;
      lane_cnt   <= '0;
      word_cnt   <= '0;
      word_buf   <= '0;
      o_ready    <= 1'b0;
      o_wr_en    <= 1'b0;
      o_wr_addr0 <= '0;
      o_wr_data0 <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      o_wr_en <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            base_q   <= i_base_addr;
            target_q <= i_num_words;
            lane_cnt <= '0;
            word_cnt <= '0;
            word_buf <= '0;
            o_busy   <= 1'b1;
            if (i_num_words == '0) begin
              state   <= DONE;
              o_ready <= 1'b0;
            end else begin
              state   <= LOAD;
              o_ready <= 1'b1;
            end
          end
        end

        LOAD: begin
          if (accept) begin
            if (lane_cnt == LAST_LANE) begin
              o_wr_en    <= 1'b1;
              o_wr_addr0 <= wr_addr_next;
              o_wr_data0 <= assembled;
              word_cnt   <= words_next;
              lane_cnt   <= '0;
              word_buf   <= '0;
              if ((words_next == target_q) || i_last) begin
                state   <= DONE;
                o_ready <= 1'b0;
              end
            end else if (i_last) begin
`ifdef NN_IMG_LOADER_PAD_EN
              o_wr_en    <= 1'b1;
              o_wr_addr0 <= wr_addr_next;
              o_wr_data0 <= assembled;
              word_cnt   <= words_next;
`endif
              lane_cnt <= '0;
              word_buf <= '0;
              state    <= DONE;
              o_ready  <= 1'b0;
            end else begin
              word_buf <= assembled;
              lane_cnt <= lane_cnt + LANE_ONE;
            end
          end
        end

        // o_done lands in the first IDLE cycle, so a back-to-back start is allowed alongside it.
        DONE: begin
          state   <= IDLE;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
          o_done  <= 1'b1;
        end

        default: begin
          state   <= IDLE;
          o_ready <= 1'b0;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/nn_img_loader.md
NN_IMG_LOADER -- requirements
Module: nn_img_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, image buffer address width.
REQ-003 SHALL have parameter TOTAL_DATA_WIDTH, default DATA_WIDTH*6, packed word width (6 lanes).
REQ-004 SHALL have ports (name direction width meaning):
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  one-cycle pulse, begin a transfer
- i_base_addr  in  ADDR_WIDTH  first buffer address
- i_num_words  in  ADDR_WIDTH+1  words to write (0..2^ADDR_WIDTH)
- i_valid  in  1  pixel beat valid
- i_data  in  DATA_WIDTH  pixel
- i_last  in  1  final pixel of frame, qualified by i_valid
- o_ready  out  1  loader accepts a beat
- o_wr_en  out  1  buffer write strobe
- o_wr_addr0  out  ADDR_WIDTH  buffer write address
- o_wr_data0  out  TOTAL_DATA_WIDTH  packed word
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle completion pulse
- o_words_written  out  ADDR_WIDTH+1  words written in current/last transfer

Function
REQ-005 SHALL implement states IDLE, LOAD, DONE.
REQ-006 IDLE: on i_start, latch i_base_addr and i_num_words, clear lane counter, word counter and o_words_written; go to LOAD, or to DONE if i_num_words==0.
REQ-007 o_ready SHALL be 1 exactly when state==LOAD; o_busy SHALL be 1 in LOAD and DONE.
REQ-008 A beat SHALL be accepted when i_valid && o_ready; lane k (0..5) SHALL occupy bits [k*DATA_WIDTH +: DATA_WIDTH], lane 0 first-accepted.
REQ-009 On acceptance of lane 5, next cycle SHALL assert o_wr_en for exactly one cycle with o_wr_data0 = packed word, o_wr_addr0 = (base + word index) mod 2^ADDR_WIDTH; packing of the next word SHALL continue without stall (1 beat/cycle sustained).
REQ-010 o_words_written SHALL increment in the same cycle o_wr_en asserts.
REQ-011 When the word count reaches the latched target, state SHALL go to DONE in the cycle o_wr_en asserts; no further beats accepted.
REQ-012 i_last accepted on lane 5 SHALL write normally and end the transfer (DONE) even if target not reached.
REQ-013 i_last accepted on lanes 0..4: behaviour per REQ-019/REQ-020; transfer SHALL end (DONE) in the following cycle.
REQ-014 DONE SHALL assert o_done for exactly one cycle, then return to IDLE.
REQ-015 i_start outside IDLE SHALL be ignored; i_valid outside LOAD SHALL be ignored.
REQ-016 o_wr_en SHALL be 0 whenever no word write is due; o_wr_addr0/o_wr_data0 SHALL hold last written values.

Reset
REQ-017 i_rst high SHALL asynchronously force state IDLE, all counters 0, and o_ready, o_wr_en, o_busy, o_done, o_wr_addr0, o_wr_data0, o_words_written to 0.
REQ-018 Reset mid-LOAD SHALL discard any partial word and SHALL NOT produce a write or o_done.

Configuration
REQ-019 With NN_IMG_LOADER_PAD_EN defined, i_last on lane n<5 SHALL write the partial word next cycle with lanes n+1..5 zero, incrementing o_words_written.
REQ-020 Without NN_IMG_LOADER_PAD_EN, i_last on lane n<5 SHALL discard the partial word; no write.

Verification
REQ-021 Start base=0, num=2, stream 12 beats 0x01..0x0C, valid continuous -> writes addr 0 data 0x060504030201, addr 1 data 0x0C0B0A090807, o_done one cycle after second write, o_words_written=2.
REQ-022 Base=1022, num=3, 18 beats -> writes to 1022, 1023, 0 (wrap), o_ready low after 18th beat.
REQ-023 num=0 -> no o_ready, no write, o_done pulse two cycles after i_start.
REQ-024 num=4, 8 beats 0x11..0x18 with i_last on 8th -> with PAD_EN writes 0x161514131211 then 0x000000001817; without, only first write; o_done both cases, o_words_written 2 or 1.
REQ-025 Random i_valid gaps, i_start pulsed during LOAD, i_rst asserted after 3 beats of word 1 -> start ignored, gaps don't corrupt lane order, reset yields no write, all outputs 0.
